// File: rtl/mem_pkg.sv
// Shared types and defaults for the load/store unit in front of the word-wide RAM.
package mem_pkg;

  localparam int unsigned RAM_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_R = 2'd3
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    RESP
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between a requester and the memory access unit.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction with sign/zero extension for loads, and lane
// merge of store data into an existing RAM word for sub-word stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] ramWord,
  input  logic [31:0] wdata,
  input  logic [1:0]  addrLow,
  input  size_t       size,
  input  logic        isUnsigned,
  output logic [31:0] loadData,
  output logic [31:0] mergeData
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    lane8 = '0;
    case (addrLow)
      2'd0:    lane8 = ramWord[7:0];
      2'd1:    lane8 = ramWord[15:8];
      2'd2:    lane8 = ramWord[23:16];
      default: lane8 = ramWord[31:24];
    endcase
    lane16 = addrLow[1] ? ramWord[31:16] : ramWord[15:0];
  end

  always_comb begin
    loadData  = '0;
    mergeData = ramWord;
    case (size)
      SIZE_B: begin
        loadData = {{24{~isUnsigned & lane8[7]}}, lane8};
        case (addrLow)
          2'd0:    mergeData[7:0]   = wdata[7:0];
          2'd1:    mergeData[15:8]  = wdata[7:0];
          2'd2:    mergeData[23:16] = wdata[7:0];
          default: mergeData[31:24] = wdata[7:0];
        endcase
      end
      SIZE_H: begin
        loadData = {{16{~isUnsigned & lane16[15]}}, lane16};
        if (addrLow[1]) mergeData[31:16] = wdata[15:0];
        else            mergeData[15:0]  = wdata[15:0];
      end
      SIZE_W: begin
        loadData  = ramWord;
        mergeData = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store unit driving a single-port RAM with synchronous
// read; sub-word stores are done as read-merge-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = RAM_WORDS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus,
  output logic [31:0]        ram_address,
  output logic [31:0]        ram_dataIn,
  input  logic [31:0]        ram_dataOut,
  output logic               ram_writeEnable
);

  state_t      state, nextState;
  size_t       reqSize, sizeQ;
  logic [1:0]  addrLowQ;
  logic        unsignedQ;
  logic        writeQ;
  logic        misaligned;
  logic        reqError;
  logic        accept;
  logic [31:0] respRdataQ;
  logic        respErrorQ;
  logic [31:0] loadData;
  logic [31:0] mergeData;

  assign reqSize = size_t'(bus.req_size);
  assign accept  = bus.req_valid && (state == IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (reqSize)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = bus.req_addr[0];
      SIZE_W:  misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
    reqError = misaligned || ({2'b00, bus.req_addr[31:2]} >= RAM_WORDS);
  end

  // ram_dataIn carries the latched store data until CAPTURE replaces it with
  // the merged word, so no separate wdata latch is kept.
  mem_lane_align u_align (
    .ramWord    (ram_dataOut),
    .wdata      (ram_dataIn),
    .addrLow    (addrLowQ),
    .size       (sizeQ),
    .isUnsigned (unsignedQ),
    .loadData   (loadData),
    .mergeData  (mergeData)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (reqError)                                nextState = RESP;
          else if (bus.req_write && reqSize == SIZE_W) nextState = WRITE;
          else                                         nextState = READ;
        end
      end
      READ:    nextState = CAPTURE;
      CAPTURE: nextState = writeQ ? WRITE : RESP;
      WRITE:   nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ram_address <= '0;
      ram_dataIn  <= '0;
      addrLowQ    <= '0;
      sizeQ       <= SIZE_B;
      unsignedQ   <= 1'b0;
      writeQ      <= 1'b0;
      respRdataQ  <= '0;
      respErrorQ  <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        ram_address <= {2'b00, bus.req_addr[31:2]};
        ram_dataIn  <= bus.req_wdata;
        addrLowQ    <= bus.req_addr[1:0];
        sizeQ       <= reqSize;
        unsignedQ   <= bus.req_unsigned;
        writeQ      <= bus.req_write;
        if (reqError) begin
          respRdataQ <= '0;
          respErrorQ <= 1'b1;
        end
      end
      if (state == CAPTURE) begin
        if (writeQ) begin
          ram_dataIn <= mergeData;
        end else begin
          respRdataQ <= loadData;
          respErrorQ <= 1'b0;
        end
      end
      if (state == WRITE) begin
        respRdataQ <= '0;
        respErrorQ <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_rdata  = respRdataQ;
  assign bus.resp_error  = respErrorQ;
  assign ram_writeEnable = (state == WRITE) && !reset;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter RAM_WORDS, default 1024: number of 32-bit words in the attached RAM; word indices at or above it are out of range.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
REQ-009 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-013 resp_error  output  1  valid with resp_valid: misaligned, reserved size or out of range.
REQ-014 ram_address  output  32  word index, req_addr[31:2].
REQ-015 ram_dataIn  output  32  RAM write data.
REQ-016 ram_dataOut  input  32  RAM read data, valid one clock after ram_address is presented (synchronous read).
REQ-017 ram_writeEnable  output  1  RAM writes ram_dataIn at ram_address on the rising edge while high.

Function
REQ-018 The unit SHALL use states IDLE, READ, CAPTURE, WRITE and RESP.
REQ-019 req_ready SHALL be high only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high, and all request fields are latched on that edge.
REQ-020 An accepted request SHALL be an error if halfword addr[0]!=0, word addr[1:0]!=0, size==3, or addr[31:2]>=RAM_WORDS. IDLE then goes to RESP with resp_error=1, and no RAM write occurs.
REQ-021 Load path: IDLE->READ->CAPTURE->RESP; resp_valid is asserted 3 cycles after the accepting edge.
REQ-022 In CAPTURE the unit SHALL register the selected lane of ram_dataOut into resp_rdata, little-endian. The byte lane is addr[1:0] and the halfword lane is addr[1]. The result is sign- or zero-extended per req_unsigned.
REQ-023 Word store path: IDLE->WRITE->RESP; ram_dataIn = req_wdata; resp_valid is asserted 2 cycles after acceptance.
REQ-024 Sub-word store path: IDLE->READ->CAPTURE->WRITE->RESP. In CAPTURE the unit SHALL merge req_wdata[7:0] or [15:0] into the addressed lane of ram_dataOut; the other bytes are preserved. resp_valid is asserted 4 cycles after acceptance.
REQ-025 ram_writeEnable SHALL be high only in WRITE and only while reset is low, exactly one cycle per store.
REQ-026 ram_address SHALL equal the latched word index in every non-IDLE state and SHALL be stable throughout a request.
REQ-027 RESP SHALL last one cycle and always return to IDLE; the next request is accepted no earlier than the cycle after RESP.
REQ-028 resp_rdata and resp_error SHALL hold their values until the next RESP. resp_rdata SHALL be 0 for store and error responses.
REQ-029 req_valid asserted outside IDLE SHALL be ignored, with no latching and no side effect.

Reset
REQ-030 When reset is high on an edge, the unit SHALL enter IDLE and clear resp_valid, resp_error, resp_rdata, ram_address, ram_dataIn and the internal latches to 0. It SHALL not assert ram_writeEnable that cycle.
REQ-031 Reset mid-operation SHALL abort the request with no response and no partial write; req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 Package mem_pkg SHALL hold the size encodings (SIZE_B, SIZE_H, SIZE_W), the state enumeration and the default value of RAM_WORDS.
REQ-033 Lane extraction/extension and lane merge SHALL live in one combinational sub-module, mem_lane_align; the FSM and registers stay in mem_access_unit.

Verification
REQ-034 RAM preloaded with word0=32'h3e800093, word1=32'h7d008113, word2=32'hc1810193. Cover with a RAM model that has a synchronous read and writes on the rising edge.
REQ-035 Loads:
- lw addr 4 -> resp_rdata 32'h7d008113, 3 cycles after acceptance.
- lb addr 0 -> 32'hffffff93.
- lbu addr 0 -> 32'h00000093.
- lh addr 2 -> 32'h00003e80.
REQ-036 sb addr 9, wdata 32'h123456ef -> one write pulse; a following lw addr 8 returns 32'hc181ef93.
REQ-037 sw addr 8, wdata 32'hdeadbeef -> resp 2 cycles after acceptance; a following lw addr 8 returns 32'hdeadbeef.
REQ-038 Error cases:
- lh addr 1 -> resp_error=1 next cycle, no write.
- lw addr 4*RAM_WORDS -> resp_error=1, no write.
REQ-039 Assert reset during WRITE of sw addr 0 with wdata 32'hffffffff -> no response; a following lw addr 0 returns 32'h3e800093.
